// File: rtl/rr_arb_pkg.sv
// rr_arb2to1 shared types
// Source ids and output-register states
package rr_arb_pkg;

   typedef logic src_t;

   localparam src_t SRC_A = 1'b0;
   localparam src_t SRC_B = 1'b1;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_t;

endpackage

// File: rtl/rr_arb2to1_if.sv
// rr_arb2to1 stream bundle
// Two source streams in, one merged stream out
interface rr_arb2to1_if
   import rr_arb_pkg::*;
#(
   parameter int WIDTH = 8
);

   logic             A_valid;
   logic [WIDTH-1:0] A_data;
   logic             A_ready;
   logic             B_valid;
   logic [WIDTH-1:0] B_data;
   logic             B_ready;
   logic             Y_valid;
   logic [WIDTH-1:0] Y_data;
   logic             Y_ready;
   src_t             Y_src;

   modport master (
      output A_valid, A_data,
      input  A_ready,
      output B_valid, B_data,
      input  B_ready,
      input  Y_valid, Y_data, Y_src,
      output Y_ready
   );

   modport slave (
      input  A_valid, A_data,
      output A_ready,
      input  B_valid, B_data,
      output B_ready,
      output Y_valid, Y_data, Y_src,
      input  Y_ready
   );

endinterface

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin pick
// Lone requester always wins; a tie goes to the one not served last
module rr_pick2
   import rr_arb_pkg::*;
(
   input  logic a_valid,
   input  logic b_valid,
   input  src_t last,
   output logic grant_valid,
   output src_t grant
);

   // Pick a source from the current requests and the last winner
   always_comb begin
      grant_valid = a_valid | b_valid;
      grant       = SRC_A;
      unique case (1'b1)
         (a_valid & b_valid):  grant = ~last;
         (a_valid & ~b_valid): grant = SRC_A;
         (~a_valid & b_valid): grant = SRC_B;
         default:              grant = SRC_A;
      endcase
   end

endmodule

// File: rtl/rr_arb2to1.sv
// rr_arb2to1: round-robin 2:1 stream merge
// One-word registered output; Y_src doubles as downstream mux select
module rr_arb2to1
   import rr_arb_pkg::*;
#(
   parameter int WIDTH = 8
)(
   input logic         clk,
   input logic         rst_n,
   rr_arb2to1_if.slave bus
);

   out_state_t       state_q;
   logic [WIDTH-1:0] data_q;
   src_t             src_q;
   src_t             last_q;
   logic             grant_valid;
   src_t             grant;
   logic             load_en;
   logic             load;
   logic [WIDTH-1:0] pick_data;

   rr_pick2 u_pick (
      .a_valid     (bus.A_valid),
      .b_valid     (bus.B_valid),
      .last        (last_q),
      .grant_valid (grant_valid),
      .grant       (grant)
   );

   assign load_en   = (state_q == ST_EMPTY) | bus.Y_ready;
   assign load      = load_en & grant_valid;
   assign pick_data = (grant == SRC_B) ? bus.B_data : bus.A_data;

   // Readys are held low while reset is asserted
   assign bus.A_ready = rst_n & load & (grant == SRC_A);
   assign bus.B_ready = rst_n & load & (grant == SRC_B);

   assign bus.Y_valid = (state_q == ST_FULL);
   assign bus.Y_data  = data_q;
   assign bus.Y_src   = src_q;

   // Output register: load on grant, drain to empty, hold on stall
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         data_q  <= '0;
         src_q   <= SRC_A;
         last_q  <= SRC_B;
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (grant_valid) begin
                  state_q <= ST_FULL;
                  data_q  <= pick_data;
                  src_q   <= grant;
                  last_q  <= grant;
               end
            end
            ST_FULL: begin
               if (bus.Y_ready) begin
                  if (grant_valid) begin
                     data_q <= pick_data;
                     src_q  <= grant;
                     last_q <= grant;
                  end else begin
                     state_q <= ST_EMPTY;
                  end
               end
            end
            default: state_q <= ST_EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_rr_arb2to1.sv
// tb_rr_arb2to1: directed and random checks
// Sources are queues; a served-order model predicts Y
module tb_rr_arb2to1;
   import rr_arb_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   rr_arb2to1_if #(.WIDTH(8)) bus ();

   rr_arb2to1 #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] qa[$];
   logic [7:0] qb[$];
   logic [7:0] got_d[$];
   logic       got_s[$];
   logic [7:0] ed[$];
   logic       es[$];

   // model: word held at the output, and who was served most recently
   logic       m_v;
   logic [7:0] m_d;
   logic       m_s;
   logic       m_last;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_v    = 1'b0;
      m_d    = 8'h00;
      m_s    = 1'b0;
      m_last = 1'b1;
   endtask

   function automatic logic winner(input logic av, input logic bv);
      if (av && bv) return !m_last;
      return bv;
   endfunction

   task automatic clear_got();
      got_d.delete();
      got_s.delete();
   endtask

   task automatic tick(input logic yr);
      logic av, bv, w, room, ar, br;
      @(negedge clk);
      av = (qa.size() > 0);
      bv = (qb.size() > 0);
      bus.A_valid = av;
      bus.A_data  = av ? qa[0] : 8'h00;
      bus.B_valid = bv;
      bus.B_data  = bv ? qb[0] : 8'h00;
      bus.Y_ready = yr;
      #1;
      room = !m_v || yr;
      w    = winner(av, bv);
      ar   = rst_n && room && av && (w == SRC_A);
      br   = rst_n && room && bv && (w == SRC_B);
      chk("a_ready", 32'(bus.A_ready), 32'(ar));
      chk("b_ready", 32'(bus.B_ready), 32'(br));
      chk("ready_excl", 32'(bus.A_ready & bus.B_ready), 32'd0);
      chk("y_valid", 32'(bus.Y_valid), 32'(m_v));
      chk("y_data", 32'(bus.Y_data), 32'(m_d));
      chk("y_src", 32'(bus.Y_src), 32'(m_s));
      if (m_v && yr) begin
         got_d.push_back(bus.Y_data);
         got_s.push_back(bus.Y_src);
      end
      @(posedge clk);
      if (rst_n) begin
         if (ar || br) begin
            m_v    = 1'b1;
            m_s    = w;
            m_last = w;
            m_d    = w ? qb[0] : qa[0];
            if (ar) void'(qa.pop_front());
            else    void'(qb.pop_front());
         end else if (yr) begin
            m_v = 1'b0;
         end
      end
   endtask

   task automatic check_seq(input string tag);
      chk({tag, "_len"}, 32'(got_d.size()), 32'(ed.size()));
      for (int i = 0; i < ed.size(); i++) begin
         chk({tag, "_data"},
             (i < got_d.size()) ? 32'(got_d[i]) : 32'hDEAD,
             32'(ed[i]));
         chk({tag, "_src"},
             (i < got_s.size()) ? 32'(got_s[i]) : 32'hDEAD,
             32'(es[i]));
      end
   endtask

   initial begin
      bus.A_valid = 1'b0;
      bus.A_data  = 8'h00;
      bus.B_valid = 1'b0;
      bus.B_data  = 8'h00;
      bus.Y_ready = 1'b0;
      model_reset();

      // reset with both sources valid
      qa = {8'h11};
      qb = {8'h22};
      rst_n = 1'b0;
      tick(1'b1);
      #2 rst_n = 1'b1;
      clear_got();
      repeat (3) tick(1'b1);
      ed = {8'h11, 8'h22};
      es = {1'b0, 1'b1};
      check_seq("first");

      // alternation
      qa = {8'h01, 8'h02, 8'h03, 8'h04};
      qb = {8'h81, 8'h82, 8'h83, 8'h84};
      clear_got();
      repeat (9) tick(1'b1);
      ed = {8'h01, 8'h81, 8'h02, 8'h82, 8'h03, 8'h83, 8'h04, 8'h84};
      es = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      check_seq("alt");

      // lone source B
      qb = {8'hA0, 8'hA1, 8'hA2, 8'hA3};
      clear_got();
      repeat (5) tick(1'b1);
      ed = {8'hA0, 8'hA1, 8'hA2, 8'hA3};
      es = {1'b1, 1'b1, 1'b1, 1'b1};
      check_seq("lone");

      // backpressure with 55 held
      qa = {8'h55};
      tick(1'b1);
      qa = {8'h66};
      qb = {8'h77};
      clear_got();
      repeat (3) tick(1'b0);
      repeat (3) tick(1'b1);
      ed = {8'h55, 8'h77, 8'h66};
      es = {1'b0, 1'b1, 1'b0};
      check_seq("bp");

      // drain to empty, then one-cycle latency
      #1;
      chk("drain_valid", 32'(bus.Y_valid), 32'd0);
      chk("drain_hold", 32'(bus.Y_data), 32'h66);
      tick(1'b1);
      qa = {8'h99};
      tick(1'b1);
      #1;
      chk("lat_valid", 32'(bus.Y_valid), 32'd1);
      chk("lat_data", 32'(bus.Y_data), 32'h99);
      tick(1'b1);

      // mid-stream reset with 3C held
      qa = {8'h3C};
      tick(1'b1);
      tick(1'b0);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("mrst_valid", 32'(bus.Y_valid), 32'd0);
      chk("mrst_data", 32'(bus.Y_data), 32'd0);
      chk("mrst_src", 32'(bus.Y_src), 32'd0);
      chk("mrst_ready", 32'({bus.A_ready, bus.B_ready}), 32'd0);
      model_reset();
      #2 rst_n = 1'b1;
      qa = {8'h44};
      qb = {8'h45};
      clear_got();
      repeat (3) tick(1'b1);
      ed = {8'h44, 8'h45};
      es = {1'b0, 1'b1};
      check_seq("mrst_tie");

      // random traffic against the model
      repeat (400) begin
         if (qa.size() < 2 && $urandom_range(0, 2) != 0)
            qa.push_back(8'($urandom));
         if (qb.size() < 2 && $urandom_range(0, 2) != 0)
            qb.push_back(8'($urandom));
         tick($urandom_range(0, 3) != 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rr_arb2to1.md
# rr_arb2to1

Two-input round-robin arbiter with a registered output stage. It merges two valid/ready data streams, A and B, into one output stream Y. It also produces the select bit that steers the downstream 2:1 data multiplexer. It sits directly upstream of the mux stage, deciding each cycle which source is passed. It buffers exactly one word so that both inputs see a clean backpressure handshake.

## Interface
- WIDTH, 8, data width of A_data, B_data and Y_data.
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- A_valid  input  1  source A has a word on A_data.
- A_data  input  WIDTH  source A payload.
- A_ready  output  1  arbiter takes A_data this cycle (combinational).
- B_valid  input  1  source B has a word on B_data.
- B_data  input  WIDTH  source B payload.
- B_ready  output  1  arbiter takes B_data this cycle (combinational).
- Y_valid  output  1  registered; Y_data/Y_src hold a word.
- Y_data  output  WIDTH  registered output payload.
- Y_ready  input  1  downstream accepts Y this cycle.
- Y_src  output  1  registered; 0 = word came from A, 1 = from B. Also serves as mux select S for downstream.

## Operation
- Transfer rule on every port: a word moves when valid and ready are both 1 at a rising edge.
- load_en = !Y_valid | Y_ready: the output register is empty, or is being drained this cycle.
- Grant (combinational, from A_valid, B_valid, last):
  - only A_valid → A;
  - only B_valid → B;
  - both valid → the source other than `last`;
  - neither → no grant.
- A_ready = load_en & grant==A; B_ready = load_en & grant==B. At most one ready is high in any cycle.
- The ready outputs depend on the valid inputs, but valid never depends on ready. Sources must hold valid and data stable until their ready is seen.
- On a load:
  - Y_data ← granted data;
  - Y_src ← granted source;
  - Y_valid ← 1;
  - last ← granted source.
- Drain without load (Y_valid & Y_ready, no grant): Y_valid ← 0. Y_data and Y_src keep their old values.
- Stall (Y_valid & !Y_ready): Y_data, Y_src and Y_valid are held. Both readys are 0, and `last` is unchanged.
- Two-state view of the output register:
  - EMPTY (Y_valid=0): goes to FULL on any grant.
  - FULL (Y_valid=1): stays FULL on Y_ready with a grant, or on !Y_ready. Goes to EMPTY on Y_ready with no grant.
- Fairness: with both inputs continuously valid and Y_ready=1, the output alternates A,B,A,B…
- Data passes through unmodified; there is no width conversion.

## Timing
- Reset values (asynchronous, immediate on rst_n low):
  - Y_valid=0;
  - Y_data=0;
  - Y_src=0;
  - last=1, so A wins the first tie.
- A_ready and B_ready are 0 while rst_n is low.
- Latency: one cycle from input handshake to Y_valid.
- Throughput: one word per cycle while Y_ready=1.
- Simultaneous drain and load in the same edge is a normal case. Y_valid stays 1 and carries the new word, with no bubble.
- A single active source gets every slot. `last` never blocks a lone requester.
- Reset asserted mid-operation discards the held word. Upstream must treat any unacknowledged word as still pending.
- Reset deassertion must be synchronised externally to clk; the block itself does not synchronise it.

## Structure
- Package rr_arb_pkg holds:
  - localparams SRC_A=1'b0 and SRC_B=1'b1;
  - the typedef src_t, 1 bit, used for grant, last and Y_src.
- Sub-module rr_pick2 (purely combinational) maps {A_valid, B_valid, last} to {grant_valid, grant}. It is reusable by the team's wider arbiters.
- The top level holds the output register, the `last` pointer and the ready logic. The data select inside the top level is a WIDTH-bit 2:1 choice on grant.

## Test plan
- Reset: rst_n=0 with both sources valid. Required: Y_valid=0, Y_data=0, Y_src=0, A_ready=B_ready=0. Release reset, with A_data=8'h11 and B_data=8'h22 valid. Required: first output is 8'h11 with Y_src=0.
- Alternation: A streams 8'h01..8'h04, B streams 8'h81..8'h84, Y_ready=1 throughout. Required Y sequence: 01,81,02,82,03,83,04,84, one per cycle, with Y_src toggling each word.
- Lone source: only B valid with 8'hA0..8'hA3. Required: four consecutive outputs A0..A3, all with Y_src=1, and A_ready always 0.
- Backpressure: Y holds 8'h55, Y_ready=0 for 3 cycles, both sources valid. Required: Y_data stays 8'h55, both readys stay 0, `last` is unchanged. On Y_ready=1, the next word loads in the same edge with no bubble.
- Drain to empty: Y_valid=1, Y_ready=1, no source valid. Required: Y_valid=0 next cycle, Y_data still the old value. A later A_valid loads with one-cycle latency.
- Mid-stream reset: rst_n pulses low for half a cycle while Y_valid=1 holds 8'h3C. Required: Y_valid=0 immediately. After release, A wins the first tie.
